// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings for the slave-to-master return path:
// transfer/response constants, data-phase owner enum and default-slave states.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        SEL_NONE    = 3'd0,
        SEL_GPIO    = 3'd1,
        SEL_MEM     = 3'd2,
        SEL_BRIDGE  = 3'd3,
        SEL_DEFAULT = 3'd4
    } resp_sel_t;

    typedef enum logic [1:0] {
        D_IDLE = 2'd0,
        D_ERR1 = 2'd1,
        D_ERR2 = 2'd2
    } dslv_state_t;

    // Overlapping decoder selects resolve GPIO > MEM > BRIDGE > DEFAULT.
    function automatic resp_sel_t encode_sel(input logic g, input logic m,
                                             input logic b, input logic d);
        if (g)      return SEL_GPIO;
        else if (m) return SEL_MEM;
        else if (b) return SEL_BRIDGE;
        else if (d) return SEL_DEFAULT;
        else        return SEL_NONE;
    endfunction

endpackage

// File: rtl/ahb_default_slave.sv
// Default slave: answers active transfers to unmapped space with the
// two-cycle AHB ERROR response; IDLE/BUSY complete OKAY with no wait.
module ahb_default_slave
    import ahb_pkg::*;
(
    input  logic hclk,
    input  logic hresetn,
    input  logic i_active,
    output logic o_hready,
    output logic o_hresp
);

    dslv_state_t r_state;
    dslv_state_t w_state_nxt;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            D_IDLE:  w_state_nxt = i_active ? D_ERR1 : D_IDLE;
            D_ERR1:  w_state_nxt = D_ERR2;
            D_ERR2:  w_state_nxt = i_active ? D_ERR1 : D_IDLE;
            default: w_state_nxt = D_IDLE;
        endcase
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) r_state <= D_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Outputs depend on state only, so no path from htrans/sel to hready.
    assign o_hready = (r_state != D_ERR1);
    assign o_hresp  = (r_state == D_IDLE) ? HRESP_OKAY : HRESP_ERROR;

endmodule

// File: rtl/ahb_resp_mux.sv
// AHB-Lite return-path mux: registers the address-phase owner, routes the
// owning slave's data-phase response to the master and counts ERROR completions.
module ahb_resp_mux
    import ahb_pkg::*;
#(
    parameter int                DATA_W        = 32,
    parameter logic [DATA_W-1:0] DEFAULT_RDATA = '0,
    parameter int                ERR_CNT_W     = 8
) (
    input  logic                 hclk,
    input  logic                 hresetn,
    input  logic [1:0]           htrans,
    input  logic                 sel_gpio,
    input  logic                 sel_mem,
    input  logic                 sel_bridge,
    input  logic                 sel_default,
    input  logic [DATA_W-1:0]    hrdata_gpio,
    input  logic [DATA_W-1:0]    hrdata_mem,
    input  logic [DATA_W-1:0]    hrdata_bridge,
    input  logic                 hreadyout_gpio,
    input  logic                 hreadyout_mem,
    input  logic                 hreadyout_bridge,
    input  logic                 hresp_gpio,
    input  logic                 hresp_mem,
    input  logic                 hresp_bridge,
    input  logic                 err_clr,
    output logic [DATA_W-1:0]    hrdata,
    output logic                 hready,
    output logic                 hresp,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    resp_sel_t            w_asel;
    resp_sel_t            r_dsel;
    logic                 w_trans_act;
    logic                 w_dflt_active;
    logic                 w_dflt_hready;
    logic                 w_dflt_hresp;
    logic [ERR_CNT_W-1:0] r_err_cnt;

    assign w_asel        = encode_sel(sel_gpio, sel_mem, sel_bridge, sel_default);
    assign w_trans_act   = (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
    assign w_dflt_active = hready & w_trans_act &
                           ((w_asel == SEL_DEFAULT) || (w_asel == SEL_NONE));

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn)    r_dsel <= SEL_NONE;
        else if (hready) r_dsel <= w_asel;
    end

    ahb_default_slave u_dflt (
        .hclk     (hclk),
        .hresetn  (hresetn),
        .i_active (w_dflt_active),
        .o_hready (w_dflt_hready),
        .o_hresp  (w_dflt_hresp)
    );

    always_comb begin
        hrdata = DEFAULT_RDATA;
        hready = w_dflt_hready;
        hresp  = w_dflt_hresp;
        case (r_dsel)
            SEL_GPIO: begin
                hrdata = hrdata_gpio;
                hready = hreadyout_gpio;
                hresp  = hresp_gpio;
            end
            SEL_MEM: begin
                hrdata = hrdata_mem;
                hready = hreadyout_mem;
                hresp  = hresp_mem;
            end
            SEL_BRIDGE: begin
                hrdata = hrdata_bridge;
                hready = hreadyout_bridge;
                hresp  = hresp_bridge;
            end
            default: begin
            end
        endcase
    end

    // Clear beats a same-cycle completion; the counter sticks at all-ones.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn)
            r_err_cnt <= '0;
        else if (err_clr)
            r_err_cnt <= '0;
        else if (hready && hresp && (r_err_cnt != {ERR_CNT_W{1'b1}}))
            r_err_cnt <= r_err_cnt + 1'b1;
    end

    assign err_cnt = r_err_cnt;

endmodule

// File: tb/tb_ahb_resp_mux.sv
// Directed bench for ahb_resp_mux: a cycle-by-cycle vector table plus
// hand sequences for counter saturation/clear and reset in mid-error.
module tb_ahb_resp_mux;

    localparam logic [31:0] GD = 32'h0000_00A5;
    localparam logic [31:0] MD = 32'hDEAD_BEEF;
    localparam logic [31:0] BD = 32'h1234_5678;

    logic        hclk = 1'b0;
    logic        hresetn;
    logic [1:0]  htrans;
    logic        sel_gpio, sel_mem, sel_bridge, sel_default;
    logic [31:0] hrdata_gpio, hrdata_mem, hrdata_bridge;
    logic        hreadyout_gpio, hreadyout_mem, hreadyout_bridge;
    logic        hresp_gpio, hresp_mem, hresp_bridge;
    logic        err_clr;
    logic [31:0] hrdata;
    logic        hready, hresp;
    logic [1:0]  err_cnt;

    int n_pass = 0;
    int n_total = 0;

    always #5 hclk = ~hclk;

    ahb_resp_mux #(.DATA_W(32), .DEFAULT_RDATA(32'h0000_0000), .ERR_CNT_W(2)) dut (
        .hclk(hclk), .hresetn(hresetn), .htrans(htrans),
        .sel_gpio(sel_gpio), .sel_mem(sel_mem), .sel_bridge(sel_bridge),
        .sel_default(sel_default),
        .hrdata_gpio(hrdata_gpio), .hrdata_mem(hrdata_mem), .hrdata_bridge(hrdata_bridge),
        .hreadyout_gpio(hreadyout_gpio), .hreadyout_mem(hreadyout_mem),
        .hreadyout_bridge(hreadyout_bridge),
        .hresp_gpio(hresp_gpio), .hresp_mem(hresp_mem), .hresp_bridge(hresp_bridge),
        .err_clr(err_clr),
        .hrdata(hrdata), .hready(hready), .hresp(hresp), .err_cnt(err_cnt)
    );

    // sel = {default, bridge, mem, gpio}; rdy/rsp = {bridge, mem, gpio}
    typedef struct packed {
        logic [1:0]  trans;
        logic [3:0]  sel;
        logic [2:0]  rdy;
        logic [2:0]  rsp;
        logic        clr;
        logic        e_rdy;
        logic        e_rsp;
        logic [31:0] e_data;
        logic [1:0]  e_cnt;
    } vec_t;

    vec_t tbl[27];

    function automatic vec_t v(input logic [1:0] t, input logic [3:0] s, input logic [2:0] r,
                               input logic [2:0] p, input logic c, input logic er,
                               input logic es, input logic [31:0] ed, input logic [1:0] ec);
        vec_t x;
        x.trans = t; x.sel = s; x.rdy = r; x.rsp = p; x.clr = c;
        x.e_rdy = er; x.e_rsp = es; x.e_data = ed; x.e_cnt = ec;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic drive(input logic [1:0] t, input logic [3:0] s, input logic [2:0] r,
                         input logic [2:0] p, input logic c);
        htrans = t;
        {sel_default, sel_bridge, sel_mem, sel_gpio} = s;
        {hreadyout_bridge, hreadyout_mem, hreadyout_gpio} = r;
        {hresp_bridge, hresp_mem, hresp_gpio} = p;
        err_clr = c;
    endtask

    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    task automatic dflt_err(input logic clr, input string tag);
        drive(2'b10, 4'b1000, 3'b111, 3'b000, 1'b0);
        step();
        drive(2'b00, 4'b0000, 3'b111, 3'b000, 1'b0);
        @(negedge hclk);
        chk({tag, " err1 hready"}, {31'd0, hready}, 32'd0);
        chk({tag, " err1 hresp"}, {31'd0, hresp}, 32'd1);
        step();
        err_clr = clr;
        @(negedge hclk);
        chk({tag, " err2 hready"}, {31'd0, hready}, 32'd1);
        chk({tag, " err2 hresp"}, {31'd0, hresp}, 32'd1);
        step();
        err_clr = 1'b0;
    endtask

    initial begin
        hrdata_gpio = GD; hrdata_mem = MD; hrdata_bridge = BD;
        drive(2'b00, 4'b0000, 3'b111, 3'b000, 1'b0);
        hresetn = 1'b0;

        //            trans  sel      rdy     rsp     clr  rdy  rsp  data  cnt
        tbl[0]  = v(2'd0, 4'b0000, 3'b111, 3'b000, 1'b0, 1'b1, 1'b0, 32'h0, 2'd0);
        tbl[1]  = v(2'd2, 4'b0001, 3'b111, 3'b000, 1'b0, 1'b1, 1'b0, 32'h0, 2'd0);
        tbl[2]  = v(2'd0, 4'b0000, 3'b110, 3'b000, 1'b0, 1'b0, 1'b0, GD,    2'd0);
        tbl[3]  = v(2'd0, 4'b0000, 3'b110, 3'b000, 1'b0, 1'b0, 1'b0, GD,    2'd0);
        tbl[4]  = v(2'd0, 4'b0000, 3'b111, 3'b000, 1'b0, 1'b1, 1'b0, GD,    2'd0);
        tbl[5]  = v(2'd2, 4'b1000, 3'b111, 3'b000, 1'b0, 1'b1, 1'b0, 32'h0, 2'd0);
        tbl[6]  = v(2'd0, 4'b0000, 3'b111, 3'b000, 1'b0, 1'b0, 1'b1, 32'h0, 2'd0);
        tbl[7]  = v(2'd0, 4'b0000, 3'b111, 3'b000, 1'b0, 1'b1, 1'b1, 32'h0, 2'd0);
        tbl[8]  = v(2'd0, 4'b1000, 3'b111, 3'b000, 1'b0, 1'b1, 1'b0, 32'h0, 2'd1);
        tbl[9]  = v(2'd0, 4'b0000, 3'b111, 3'b000, 1'b0, 1'b1, 1'b0, 32'h0, 2'd1);
        tbl[10] = v(2'd2, 4'b1000, 3'b111, 3'b000, 1'b0, 1'b1, 1'b0, 32'h0, 2'd1);
        tbl[11] = v(2'd0, 4'b0000, 3'b111, 3'b000, 1'b0, 1'b0, 1'b1, 32'h0, 2'd1);
        tbl[12] = v(2'd2, 4'b0010, 3'b111, 3'b000, 1'b0, 1'b1, 1'b1, 32'h0, 2'd1);
        tbl[13] = v(2'd0, 4'b0000, 3'b111, 3'b000, 1'b0, 1'b1, 1'b0, MD,    2'd2);
        tbl[14] = v(2'd2, 4'b0101, 3'b111, 3'b000, 1'b0, 1'b1, 1'b0, 32'h0, 2'd2);
        tbl[15] = v(2'd0, 4'b0000, 3'b111, 3'b000, 1'b0, 1'b1, 1'b0, GD,    2'd2);
        tbl[16] = v(2'd3, 4'b0000, 3'b111, 3'b000, 1'b0, 1'b1, 1'b0, 32'h0, 2'd2);
        tbl[17] = v(2'd0, 4'b0000, 3'b111, 3'b000, 1'b0, 1'b0, 1'b1, 32'h0, 2'd2);
        tbl[18] = v(2'd0, 4'b0000, 3'b111, 3'b000, 1'b0, 1'b1, 1'b1, 32'h0, 2'd2);
        tbl[19] = v(2'd0, 4'b0000, 3'b111, 3'b000, 1'b0, 1'b1, 1'b0, 32'h0, 2'd3);
        tbl[20] = v(2'd2, 4'b0100, 3'b111, 3'b000, 1'b0, 1'b1, 1'b0, 32'h0, 2'd3);
        tbl[21] = v(2'd0, 4'b0000, 3'b111, 3'b100, 1'b0, 1'b1, 1'b1, BD,    2'd3);
        tbl[22] = v(2'd0, 4'b0000, 3'b111, 3'b000, 1'b0, 1'b1, 1'b0, 32'h0, 2'd3);
        tbl[23] = v(2'd2, 4'b1000, 3'b111, 3'b000, 1'b0, 1'b1, 1'b0, 32'h0, 2'd3);
        tbl[24] = v(2'd0, 4'b0000, 3'b111, 3'b000, 1'b0, 1'b0, 1'b1, 32'h0, 2'd3);
        tbl[25] = v(2'd0, 4'b0000, 3'b111, 3'b000, 1'b1, 1'b1, 1'b1, 32'h0, 2'd3);
        tbl[26] = v(2'd0, 4'b0000, 3'b111, 3'b000, 1'b0, 1'b1, 1'b0, 32'h0, 2'd0);

        repeat (2) @(posedge hclk);
        #1 hresetn = 1'b1;

        for (int i = 0; i < 27; i++) begin
            drive(tbl[i].trans, tbl[i].sel, tbl[i].rdy, tbl[i].rsp, tbl[i].clr);
            @(negedge hclk);
            chk($sformatf("vec%0d hready", i), {31'd0, hready}, {31'd0, tbl[i].e_rdy});
            chk($sformatf("vec%0d hresp", i), {31'd0, hresp}, {31'd0, tbl[i].e_rsp});
            chk($sformatf("vec%0d hrdata", i), hrdata, tbl[i].e_data);
            chk($sformatf("vec%0d err_cnt", i), {30'd0, err_cnt}, {30'd0, tbl[i].e_cnt});
            step();
        end
        drive(2'b00, 4'b0000, 3'b111, 3'b000, 1'b0);

        for (int k = 0; k < 5; k++) dflt_err(1'b0, $sformatf("sat%0d", k));
        @(negedge hclk);
        chk("saturated err_cnt", {30'd0, err_cnt}, 32'd3);
        step();
        dflt_err(1'b1, "clr");
        @(negedge hclk);
        chk("cleared err_cnt", {30'd0, err_cnt}, 32'd0);
        step();

        dflt_err(1'b0, "pre_rst");
        drive(2'b10, 4'b1000, 3'b111, 3'b000, 1'b0);
        step();
        drive(2'b00, 4'b0000, 3'b111, 3'b000, 1'b0);
        @(negedge hclk);
        chk("pre-reset err_cnt", {30'd0, err_cnt}, 32'd1);
        chk("pre-reset err1 hready", {31'd0, hready}, 32'd0);
        #1 hresetn = 1'b0;
        #1;
        chk("async rst hready", {31'd0, hready}, 32'd1);
        chk("async rst hresp", {31'd0, hresp}, 32'd0);
        chk("async rst err_cnt", {30'd0, err_cnt}, 32'd0);
        chk("async rst hrdata", hrdata, 32'd0);
        step();
        hresetn = 1'b1;
        @(negedge hclk);
        chk("post-rst hready", {31'd0, hready}, 32'd1);
        chk("post-rst hresp", {31'd0, hresp}, 32'd0);
        step();
        @(negedge hclk);
        chk("post-rst hready+1", {31'd0, hready}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
